pwm_capture: RTL and testbench

- Reader side of the multi-channel PWM driver.
- Samples STAGE PWM lines and measures each channel's high-time, in clocks, over one hsync-delimited period.
- Snapshots the counts at each hsync and streams them out one DWIDTH-bit word per channel on a valid/ready port, channel 0 first.
- Used as loopback checker and duty-readback path: the recovered words equal the data words originally loaded into the driver.

---
 rtl/pwm_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: reader side of the multi-channel PWM driver.
// Measures each channel's high-time (in clocks) over one hsync-delimited
// period, snapshots all counts at hsync and streams them out one word per
// channel, channel 0 first, on a valid/ready port.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-low reset
//   hsync      - single-cycle period-start pulse
//   pwm_in     - PWM lines, bit i = channel i
//   out_valid  - out_data/out_chan hold a valid word
//   out_ready  - downstream accepts the word when high with out_valid
//   out_data   - measured high-time of channel out_chan
//   out_chan   - channel index of out_data
//   frame_done - one-cycle pulse after the last channel word is accepted
//   overrun    - one-cycle pulse when an hsync snapshot is dropped
//
// Optional feature macro: PWM_CAPTURE_SYNC_EN
//   defined   - pwm_in and hsync each pass through a two-flop synchronizer
//   undefined - inputs used directly (same-clock source)
module pwm_capture #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned STAGE  = 8,
  localparam int unsigned CW    = (STAGE > 1) ? $clog2(STAGE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsync,
  input  logic [0:STAGE-1]  pwm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [CW-1:0]     out_chan,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [DWIDTH-1:0] HC_MAX = '1;
  localparam logic [CW-1:0]     LAST_IDX = CW'(STAGE - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  logic [0:STAGE-1] w_pwm;
  logic             w_hsync;

  // Input stage: optional two-flop synchronizers with equal delay on both paths
`ifdef PWM_CAPTURE_SYNC_EN
  logic [0:STAGE-1] r_pwm_s1;
  logic [0:STAGE-1] r_pwm_s2;
  logic             r_hs_s1;
  logic             r_hs_s2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pwm_s1 <= '0;
      r_pwm_s2 <= '0;
      r_hs_s1  <= 1'b0;
      r_hs_s2  <= 1'b0;
    end else begin
      r_pwm_s1 <= pwm_in;
      r_pwm_s2 <= r_pwm_s1;
      r_hs_s1  <= hsync;
      r_hs_s2  <= r_hs_s1;
    end
  end

  assign w_pwm   = r_pwm_s2;
  assign w_hsync = r_hs_s2;
`else
  assign w_pwm   = pwm_in;
  assign w_hsync = hsync;
`endif

  logic [DWIDTH-1:0] r_hc   [STAGE];
  logic [DWIDTH-1:0] r_snap [STAGE];
  logic              r_armed;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_idx;
  logic [CW-1:0]     w_idx_nxt;

  logic              r_out_valid;
  logic [DWIDTH-1:0] r_out_data;
  logic [CW-1:0]     r_out_chan;
  logic              r_frame_done;
  logic              r_overrun;

  logic              w_out_valid_nxt;
  logic [DWIDTH-1:0] w_out_data_nxt;
  logic [CW-1:0]     w_out_chan_nxt;
  logic              w_frame_done_nxt;
  logic              w_overrun_nxt;

  logic              w_accept;
  logic              w_last;
  logic              w_free;
  logic              w_snap_take;
  logic              w_drop;

  // High-time counters: hsync restarts the count with the hsync-cycle sample
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(STAGE); i++) begin
        r_hc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(STAGE); i++) begin
        if (w_hsync) begin
          r_hc[i] <= DWIDTH'(w_pwm[i]);
        end else if (w_pwm[i] && (r_hc[i] != HC_MAX)) begin
          r_hc[i] <= r_hc[i] + DWIDTH'(1);
        end
      end
    end
  end

  // The first hsync after reset only opens the first full period
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_armed <= 1'b0;
    end else if (w_hsync) begin
      r_armed <= 1'b1;
    end
  end

  // Snapshot captures counts from before the hsync restart
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(STAGE); i++) begin
        r_snap[i] <= '0;
      end
    end else if (w_snap_take) begin
      for (int i = 0; i < int'(STAGE); i++) begin
        r_snap[i] <= r_hc[i];
      end
    end
  end

  // Beat handshake and buffer-availability decode
  assign w_accept    = r_out_valid && out_ready;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_free      = (r_state == S_IDLE) || (w_accept && w_last);
  assign w_snap_take = w_hsync && r_armed && w_free;
  assign w_drop      = w_hsync && r_armed && !w_free;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // FSM next-state and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_frame_done_nxt = 1'b0;
    w_overrun_nxt    = w_drop;
    w_out_valid_nxt  = 1'b0;
    w_out_data_nxt   = '0;
    w_out_chan_nxt   = '0;

    unique case (r_state)
      S_IDLE: begin
        if (w_snap_take) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = '0;
        end
      end
      S_SEND: begin
        if (w_accept) begin
          if (w_last) begin
            w_frame_done_nxt = 1'b1;
            w_idx_nxt        = '0;
            // hsync coinciding with the last accept starts the next frame seamlessly
            w_state_nxt      = w_snap_take ? S_SEND : S_IDLE;
          end else begin
            w_idx_nxt = r_idx + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    if (w_state_nxt == S_SEND) begin
      w_out_valid_nxt = 1'b1;
      w_out_chan_nxt  = w_idx_nxt;
      // A fresh snapshot is not yet in r_snap, so forward channel 0 from the counter
      w_out_data_nxt  = w_snap_take ? r_hc[0] : r_snap[w_idx_nxt];
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_chan   <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_out_valid  <= w_out_valid_nxt;
      r_out_data   <= w_out_data_nxt;
      r_out_chan   <= w_out_chan_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_chan   = r_out_chan;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture (default build, direct inputs).
module tb_pwm_capture;

  localparam int unsigned DW  = 8;
  localparam int unsigned ST  = 8;
  localparam int unsigned CW  = 3;
  localparam int          SAT = 255;

  logic           clk = 1'b0;
  logic           rst;
  logic           hsync;
  logic [0:ST-1]  pwm_in;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [CW-1:0]  out_chan;
  logic           frame_done;
  logic           overrun;

  pwm_capture #(.DWIDTH(DW), .STAGE(ST)) dut (
    .clk        (clk),
    .rst        (rst),
    .hsync      (hsync),
    .pwm_in     (pwm_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] chan;
  } beat_t;

  typedef struct {
    string       name;
    int          period;
    int          len0;
    int          len1;
    int          base;
    int          step;
    logic [3:0]  rdy;
    int          nhs;
    int          exp_frames;
    int          exp_ovr;
  } vec_t;

  beat_t      sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         frames  = 0;
  int         overruns = 0;
  int         pos;
  int         cyc;
  int         lens[ST];
  int         tally[ST];
  logic [3:0] rdy_pat;

  logic          hold_vld = 1'b0;
  logic [DW-1:0] hold_data;
  logic [CW-1:0] hold_chan;

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Output monitor: scoreboard pops, stall stability, pulse counting
  always @(negedge clk) begin
    if (!rst) begin
      hold_vld = 1'b0;
      sb_q.delete();
    end else begin
      if (frame_done) frames++;
      if (overrun) overruns++;
      if (hold_vld) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(hold_data));
        check("stall_chan", int'(out_chan), int'(hold_chan));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          beat_t b;
          b = sb_q.pop_front();
          check("beat_data", int'(out_data), int'(b.data));
          check("beat_chan", int'(out_chan), int'(b.chan));
        end
      end
      hold_vld  = out_valid && !out_ready;
      hold_data = out_data;
      hold_chan = out_chan;
    end
  end

  // One stimulus cycle; the bench tallies pwm highs itself as the reference
  task automatic drive_cycle(input bit hs, input bit push);
    if (hs) begin
      if (push) begin
        for (int i = 0; i < int'(ST); i++) begin
          beat_t b;
          b.data = DW'(tally[i]);
          b.chan = CW'(i);
          sb_q.push_back(b);
        end
      end
      pos = 0;
    end
    for (int i = 0; i < int'(ST); i++) begin
      logic bit_v;
      bit_v = (pos < lens[i]);
      pwm_in[i] = bit_v;
      if (hs) tally[i] = bit_v ? 1 : 0;
      else if (bit_v && tally[i] < SAT) tally[i]++;
    end
    hsync = hs;
    out_ready = rdy_pat[cyc % 4];
    @(posedge clk);
    #1;
    pos++;
    cyc++;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic set_lens(input int l0, input int l1, input int base, input int step);
    for (int i = 0; i < int'(ST); i++) begin
      lens[i] = (i == 0) ? l0 : (i == 1) ? l1 : base + step * i;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    hsync = 1'b0;
    pwm_in = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pos = 1000;
    cyc = 0;
    for (int i = 0; i < int'(ST); i++) tally[i] = 0;
    @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_chan", int'(out_chan), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[4];

  initial begin
    int f0;
    int o0;
    int vcnt;

    tbl[0] = '{"loopback", 256, 5, 15, 5, 10, 4'b1111, 2, 1, 0};
    tbl[1] = '{"backpressure", 256, 5, 15, 5, 10, 4'b1001, 3, 2, 0};
    tbl[2] = '{"sat_zero", 300, 1000, 0, 200, 10, 4'b1111, 2, 1, 0};
    tbl[3] = '{"short_period", 40, 5, 15, 5, 10, 4'b1101, 4, 3, 0};

    rst = 1'b0;
    hsync = 1'b0;
    pwm_in = '0;
    out_ready = 1'b0;
    rdy_pat = 4'b1111;
    set_lens(0, 0, 0, 0);

    // Table-driven period scenarios
    for (int t = 0; t < 4; t++) begin
      set_lens(tbl[t].len0, tbl[t].len1, tbl[t].base, tbl[t].step);
      rdy_pat = tbl[t].rdy;
      do_reset();
      f0 = frames;
      o0 = overruns;
      idle_cycles(3);
      for (int k = 0; k < tbl[t].nhs; k++) begin
        drive_cycle(1'b1, k > 0);
        idle_cycles(tbl[t].period - 1);
      end
      check({tbl[t].name, "_frames"}, frames - f0, tbl[t].exp_frames);
      check({tbl[t].name, "_overrun"}, overruns - o0, tbl[t].exp_ovr);
      check({tbl[t].name, "_drained"}, sb_q.size(), 0);
    end

    // Overrun: stalled frame, two extra hsyncs are dropped
    set_lens(5, 15, 5, 10);
    rdy_pat = 4'b0000;
    do_reset();
    f0 = frames;
    o0 = overruns;
    idle_cycles(3);
    drive_cycle(1'b1, 1'b0);
    idle_cycles(255);
    drive_cycle(1'b1, 1'b1);
    idle_cycles(19);
    drive_cycle(1'b1, 1'b0);
    idle_cycles(19);
    drive_cycle(1'b1, 1'b0);
    idle_cycles(19);
    check("ovr_held_chan", int'(out_chan), 0);
    check("ovr_held_data", int'(out_data), 5);
    check("ovr_count", overruns - o0, 2);
    rdy_pat = 4'b1111;
    idle_cycles(30);
    check("ovr_frames", frames - f0, 1);
    check("ovr_drained", sb_q.size(), 0);

    // Last-beat coincidence: hsync exactly when channel 7 is accepted
    set_lens(8, 7, 8, -1);
    rdy_pat = 4'b1111;
    do_reset();
    f0 = frames;
    o0 = overruns;
    idle_cycles(3);
    drive_cycle(1'b1, 1'b0);
    idle_cycles(7);
    vcnt = 0;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1'b1, 1'b1);
      if (out_valid) vcnt++;
      for (int j = 0; j < 7; j++) begin
        drive_cycle(1'b0, 1'b0);
        if (out_valid) vcnt++;
      end
    end
    check("coin_valid_cycles", vcnt, 32);
    idle_cycles(10);
    check("coin_frames", frames - f0, 4);
    check("coin_overrun", overruns - o0, 0);
    check("coin_drained", sb_q.size(), 0);

    // Reset mid-frame after three accepted beats
    set_lens(5, 15, 5, 10);
    rdy_pat = 4'b1111;
    do_reset();
    idle_cycles(3);
    drive_cycle(1'b1, 1'b0);
    idle_cycles(255);
    drive_cycle(1'b1, 1'b1);
    idle_cycles(3);
    check("mid_pending", sb_q.size(), 5);
    f0 = frames;
    rst = 1'b0;
    hsync = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("mid_valid_after_rst", int'(out_valid), 0);
    check("mid_drained", sb_q.size(), 0);
    idle_cycles(4);
    check("mid_no_frame_done", frames - f0, 0);
    vcnt = 0;
    drive_cycle(1'b1, 1'b0);
    if (out_valid) vcnt++;
    for (int j = 0; j < 255; j++) begin
      drive_cycle(1'b0, 1'b0);
      if (out_valid) vcnt++;
    end
    check("mid_first_hsync_silent", vcnt, 0);
    drive_cycle(1'b1, 1'b1);
    idle_cycles(20);
    check("mid_resume_frames", frames - f0, 1);
    check("mid_resume_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
